// File: rtl/microcode_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// microcode_sequencer_pkg
//   Shared microcode definitions for the sequencer: default field widths,
//   positions of the control bits inside a microword, the position of the
//   opcode field inside the instruction register, and the sequencer states.
// -----------------------------------------------------------------------------
package microcode_sequencer_pkg;

    // Default widths
    localparam int OPC_BITS_DEF = 8;   // opcode width
    localparam int T_BITS_DEF   = 3;   // T-state width
    localparam int UW_BITS_DEF  = 16;  // microword / IR / bus width

    // Microword control bits
    localparam int END_BIT_DEF  = 15;  // end of instruction, reset T-state
    localparam int II_BIT_DEF   = 14;  // load IR from bus

    // Opcode lives in the top byte of the IR: ir[OPC_MSB -: OPC_BITS]
    localparam int OPC_MSB      = 15;

    typedef enum logic [1:0] {
        ST_SYNC = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } seq_state_e;

endpackage

// File: rtl/microcode_sequencer_seq_ctl.sv
// -----------------------------------------------------------------------------
// microcode_sequencer_seq_ctl
//   SYNC/RUN/HALT state machine of the microcode sequencer. Decides when the
//   external T-state counter is held in reset, flags instruction boundaries
//   and freezes the CPU at T0 between instructions while halted.
//
// Ports
//   clk                 rising-edge clock
//   reset_bar           asynchronous active-low reset
//   t_last_i            current T-state is the implicit last step (all ones)
//   uw_end_i            END bit of the current microword
//   halt_req_i          level: halt at the next instruction boundary
//   resume_i            pulse: leave HALT
//   run_o               sequencer is in RUN (microword gated onto ctrl)
//   tstate_reset_bar_o  registered, low holds the T-state counter at 0
//   halted_o            high while in HALT
//   instr_done_o        registered one-cycle pulse after each boundary
// -----------------------------------------------------------------------------
module microcode_sequencer_seq_ctl
    import microcode_sequencer_pkg::*;
(
    input  logic clk,
    input  logic reset_bar,
    input  logic t_last_i,
    input  logic uw_end_i,
    input  logic halt_req_i,
    input  logic resume_i,
    output logic run_o,
    output logic tstate_reset_bar_o,
    output logic halted_o,
    output logic instr_done_o
);

    seq_state_e state_q, state_d;
    logic       tsr_q,   tsr_d;
    logic       done_q,  done_d;
    logic       boundary;

    // An instruction ends either explicitly (END bit) or by running off the
    // last T-state, in which case the counter simply wraps to 0 by itself.
    assign boundary = uw_end_i | t_last_i;

    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned; an unassigned path would infer a latch.
    always_comb begin
        state_d = state_q;
        tsr_d   = 1'b1;
        done_d  = 1'b0;

        unique case (state_q)
            ST_SYNC: begin
                // T is guaranteed 0 here because the counter was held in reset.
                if (halt_req_i) begin
                    state_d = ST_HALT;
                    tsr_d   = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (boundary) begin
                    done_d = 1'b1;
                    if (halt_req_i) begin
                        state_d = ST_HALT;
                        tsr_d   = 1'b0;
                    end else if (uw_end_i) begin
                        // One-cycle clear; the counter clears asynchronously
                        // so the next rising edge already sees T=0.
                        tsr_d = 1'b0;
                    end
                end
            end

            ST_HALT: begin
                // resume wins over a still-asserted halt_req; the re-halt
                // then happens at the next boundary.
                if (resume_i) begin
                    state_d = ST_RUN;
                end else begin
                    tsr_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_SYNC;
                tsr_d   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values sampled at the edge.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state_q <= ST_SYNC;
            tsr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tsr_q   <= tsr_d;
            done_q  <= done_d;
        end
    end

    assign run_o              = (state_q == ST_RUN);
    assign halted_o           = (state_q == ST_HALT);
    assign tstate_reset_bar_o = tsr_q;
    assign instr_done_o       = done_q;

endmodule

// File: rtl/microcode_sequencer.sv
// -----------------------------------------------------------------------------
// microcode_sequencer
//   Holds the instruction register, forms the microcode ROM address
//   {opcode, T}, gates the returned microword onto the control outputs and
//   drives the reset of the external T-state counter through seq_ctl.
//
// Ports
//   clk               rising-edge clock (the T-state counter uses the falling edge)
//   reset_bar         asynchronous active-low reset
//   T                 current T-state from the T-state counter
//   uword             microword read from the ROM at uaddr
//   bus               CPU data bus, source for IR loads
//   halt_req          level: halt at the next instruction boundary
//   resume            pulse: leave HALT (ignored elsewhere)
//   uaddr             combinational ROM address {ir opcode, T}
//   ctrl              uword in RUN, zero in SYNC and HALT
//   ir                instruction register
//   tstate_reset_bar  registered reset for the T-state counter (low holds T=0)
//   halted            high while in HALT
//   instr_done        one-cycle pulse after each instruction boundary
// -----------------------------------------------------------------------------
module microcode_sequencer
    import microcode_sequencer_pkg::*;
#(
    parameter int OPC_BITS = OPC_BITS_DEF,
    parameter int T_BITS   = T_BITS_DEF,
    parameter int UW_BITS  = UW_BITS_DEF,
    parameter int END_BIT  = END_BIT_DEF,
    parameter int II_BIT   = II_BIT_DEF
) (
    input  logic                         clk,
    input  logic                         reset_bar,
    input  logic [T_BITS-1:0]            T,
    input  logic [UW_BITS-1:0]           uword,
    input  logic [UW_BITS-1:0]           bus,
    input  logic                         halt_req,
    input  logic                         resume,
    output logic [OPC_BITS+T_BITS-1:0]   uaddr,
    output logic [UW_BITS-1:0]           ctrl,
    output logic [UW_BITS-1:0]           ir,
    output logic                         tstate_reset_bar,
    output logic                         halted,
    output logic                         instr_done
);

    logic [UW_BITS-1:0] ir_q, ir_d;
    logic               run;

    microcode_sequencer_seq_ctl u_seq_ctl (
        .clk                (clk),
        .reset_bar          (reset_bar),
        .t_last_i           (&T),
        .uw_end_i           (uword[END_BIT]),
        .halt_req_i         (halt_req),
        .resume_i           (resume),
        .run_o              (run),
        .tstate_reset_bar_o (tstate_reset_bar),
        .halted_o           (halted),
        .instr_done_o       (instr_done)
    );

    // IR only loads while running; in SYNC/HALT the microword is not acted on.
    always_comb begin
        ir_d = ir_q;
        if (run && uword[II_BIT]) begin
            ir_d = bus;
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

    assign ir    = ir_q;
    assign uaddr = {ir_q[OPC_MSB -: OPC_BITS], T};
    assign ctrl  = run ? uword : '0;

endmodule

// File: tb/tb_microcode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_microcode_sequencer
//   Bench for microcode_sequencer: a behavioural 74161-style T-state counter
//   (falling-edge count, asynchronous clear) and a microcode ROM array close
//   the loop around the DUT; a rule-level model predicts IR, T and outputs.
// -----------------------------------------------------------------------------
module tb_microcode_sequencer;

    localparam int M_SYNC = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk;
    logic        reset_bar;
    logic [2:0]  t_cnt = 3'd0;
    logic [15:0] uword;
    logic [15:0] bus;
    logic        halt_req;
    logic        resume;
    logic [10:0] uaddr;
    logic [15:0] ctrl;
    logic [15:0] ir;
    logic        tstate_reset_bar;
    logic        halted;
    logic        instr_done;

    logic [15:0] rom [2048];

    int checks = 0;
    int errors = 0;

    // Model of the sequencer, in terms of the behavioural rules
    int          m_mode;
    logic [2:0]  m_t;
    logic [15:0] m_ir;
    logic        m_tsr;
    logic        m_done;

    microcode_sequencer dut (
        .clk              (clk),
        .reset_bar        (reset_bar),
        .T                (t_cnt),
        .uword            (uword),
        .bus              (bus),
        .halt_req         (halt_req),
        .resume           (resume),
        .uaddr            (uaddr),
        .ctrl             (ctrl),
        .ir               (ir),
        .tstate_reset_bar (tstate_reset_bar),
        .halted           (halted),
        .instr_done       (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // T-state counter: counts on the falling edge, clears asynchronously
    always @(negedge clk or negedge tstate_reset_bar) begin
        if (!tstate_reset_bar) t_cnt <= 3'd0;
        else                   t_cnt <= t_cnt + 3'd1;
    end

    assign uword = rom[uaddr];

    function automatic logic [15:0] exp_ctrl();
        logic [10:0] a;
        a = {m_ir[15:8], m_t};
        return (m_mode == M_RUN) ? rom[a] : 16'h0000;
    endfunction

    task automatic model_reset();
        m_mode = M_SYNC;
        m_t    = 3'd0;
        m_ir   = 16'h0000;
        m_tsr  = 1'b0;
        m_done = 1'b0;
    endtask

    // One clock: model applies the rules to the pre-edge inputs, then the
    // DUT and counter advance. Returns one time unit after the falling edge.
    task automatic tick();
        logic [15:0] w;
        logic [10:0] a;
        logic        bnd;
        a = {m_ir[15:8], m_t};
        w = rom[a];
        m_done = 1'b0;
        case (m_mode)
            M_SYNC: begin
                m_mode = halt_req ? M_HALT : M_RUN;
                m_tsr  = !halt_req;
            end
            M_RUN: begin
                if (w[14]) m_ir = bus;
                bnd    = w[15] || (m_t == 3'd7);
                m_done = bnd;
                if (bnd && halt_req) begin
                    m_mode = M_HALT;
                    m_tsr  = 1'b0;
                end else begin
                    m_tsr = !w[15];
                end
            end
            default: begin
                if (resume) begin
                    m_mode = M_RUN;
                    m_tsr  = 1'b1;
                end else begin
                    m_tsr = 1'b0;
                end
            end
        endcase
        @(posedge clk);
        #1;
        if (!m_tsr) m_t = 3'd0;
        @(negedge clk);
        if (m_tsr) m_t = m_t + 3'd1;
        #1;
    endtask

    task automatic test_reset();
        reset_bar = 1'b0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        bus       = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h want 0000", ir); end
        checks++; if (tstate_reset_bar !== 1'b0) begin errors++; $display("FAIL reset_tsr: got %b want 0", tstate_reset_bar); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", instr_done); end
        checks++; if (ctrl !== 16'h0000) begin errors++; $display("FAIL reset_ctrl: got %h want 0000", ctrl); end
        reset_bar = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        checks++; if (tstate_reset_bar !== 1'b0 || t_cnt !== 3'd0 || ctrl !== 16'h0000) begin
            errors++; $display("FAIL sync_hold: tsr=%b T=%0d ctrl=%h want tsr=0 T=0 ctrl=0000", tstate_reset_bar, t_cnt, ctrl);
        end
        tick();
        checks++; if (tstate_reset_bar !== 1'b1 || t_cnt !== 3'd1) begin
            errors++; $display("FAIL sync_to_run: tsr=%b T=%0d want tsr=1 T=1", tstate_reset_bar, t_cnt);
        end
        checks++; if (ctrl !== 16'h4000) begin errors++; $display("FAIL run_ctrl: got %h want 4000", ctrl); end
    endtask

    task automatic test_ir_load();
        bus = 16'hA53C;
        tick();
        checks++; if (ir !== 16'hA53C) begin errors++; $display("FAIL ir_load: got %h want a53c", ir); end
        checks++; if (ir !== m_ir) begin errors++; $display("FAIL ir_model: got %h model %h", ir, m_ir); end
        tick();
        checks++; if (uaddr !== 11'h52B) begin errors++; $display("FAIL uaddr_t3: got %h want 52b", uaddr); end
    endtask

    task automatic test_end_of_instr();
        tick();
        checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL end_done: got %b want 1", instr_done); end
        checks++; if (tstate_reset_bar !== 1'b0 || t_cnt !== 3'd0) begin
            errors++; $display("FAIL end_clear: tsr=%b T=%0d want tsr=0 T=0", tstate_reset_bar, t_cnt);
        end
        checks++; if (uaddr !== 11'h528 || ctrl !== 16'h0123) begin
            errors++; $display("FAIL uaddr_t0: uaddr=%h ctrl=%h want 528 0123", uaddr, ctrl);
        end
        tick();
        checks++; if (instr_done !== 1'b0 || tstate_reset_bar !== 1'b1 || t_cnt !== 3'd1) begin
            errors++; $display("FAIL end_after: done=%b tsr=%b T=%0d want 0 1 1", instr_done, tstate_reset_bar, t_cnt);
        end
    endtask

    task automatic test_wrap();
        bus = 16'h3C00;
        tick();
        checks++; if (ir !== 16'h3C00 || t_cnt !== 3'd2) begin
            errors++; $display("FAIL wrap_load: ir=%h T=%0d want 3c00 2", ir, t_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (instr_done !== 1'b0 || tstate_reset_bar !== 1'b1 || t_cnt !== 3'(i + 3)) begin
                errors++; $display("FAIL wrap_step%0d: done=%b tsr=%b T=%0d", i, instr_done, tstate_reset_bar, t_cnt);
            end
        end
        tick();
        checks++; if (instr_done !== 1'b1 || tstate_reset_bar !== 1'b1 || t_cnt !== 3'd0) begin
            errors++; $display("FAIL wrap_t7: done=%b tsr=%b T=%0d want 1 1 0", instr_done, tstate_reset_bar, t_cnt);
        end
    endtask

    task automatic test_halt();
        bus = 16'h5A00;
        tick();
        tick();
        checks++; if (ir !== 16'h5A00 || t_cnt !== 3'd2) begin
            errors++; $display("FAIL halt_setup: ir=%h T=%0d want 5a00 2", ir, t_cnt);
        end
        halt_req = 1'b1;
        tick();
        tick();
        checks++; if (halted !== 1'b0 || instr_done !== 1'b0 || t_cnt !== 3'd4) begin
            errors++; $display("FAIL halt_midinstr: halted=%b done=%b T=%0d want 0 0 4", halted, instr_done, t_cnt);
        end
        tick();
        checks++; if (halted !== 1'b1 || instr_done !== 1'b1 || tstate_reset_bar !== 1'b0 || ctrl !== 16'h0000) begin
            errors++; $display("FAIL halt_enter: halted=%b done=%b tsr=%b ctrl=%h", halted, instr_done, tstate_reset_bar, ctrl);
        end
        halt_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (halted !== 1'b1 || ctrl !== 16'h0000 || t_cnt !== 3'd0 || instr_done !== 1'b0 || uaddr !== 11'h2D0) begin
                errors++; $display("FAIL halt_hold%0d: halted=%b ctrl=%h T=%0d done=%b uaddr=%h", i, halted, ctrl, t_cnt, instr_done, uaddr);
            end
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        checks++; if (halted !== 1'b0 || tstate_reset_bar !== 1'b1 || t_cnt !== 3'd1) begin
            errors++; $display("FAIL resume: halted=%b tsr=%b T=%0d want 0 1 1", halted, tstate_reset_bar, t_cnt);
        end
        tick();
        checks++; if (t_cnt !== 3'd2) begin errors++; $display("FAIL resume_t2: got %0d want 2", t_cnt); end
    endtask

    task automatic test_reset_mid();
        int n;
        bus = 16'h3C00;
        n = 0;
        while (t_cnt !== 3'd5 && n < 16) begin
            tick();
            n++;
        end
        checks++; if (t_cnt !== 3'd5) begin errors++; $display("FAIL reach_t5: T=%0d after %0d cycles", t_cnt, n); end
        reset_bar = 1'b0;
        #1;
        checks++; if (ir !== 16'h0000 || tstate_reset_bar !== 1'b0 || t_cnt !== 3'd0 || halted !== 1'b0 || instr_done !== 1'b0) begin
            errors++; $display("FAIL async_reset: ir=%h tsr=%b T=%0d halted=%b done=%b", ir, tstate_reset_bar, t_cnt, halted, instr_done);
        end
        @(posedge clk);
        #1;
        reset_bar = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        checks++; if (tstate_reset_bar !== 1'b0 || t_cnt !== 3'd0) begin
            errors++; $display("FAIL resync_hold: tsr=%b T=%0d want 0 0", tstate_reset_bar, t_cnt);
        end
        tick();
        checks++; if (tstate_reset_bar !== 1'b1 || t_cnt !== 3'd1 || halted !== 1'b0) begin
            errors++; $display("FAIL resync_run: tsr=%b T=%0d halted=%b want 1 1 0", tstate_reset_bar, t_cnt, halted);
        end
    endtask

    task automatic test_random();
        logic [15:0] w;
        int          shown;
        shown = 0;
        for (int i = 0; i < 2048; i++) begin
            w     = 16'($urandom);
            w[15] = ($urandom_range(0, 3) == 0);
            w[14] = ($urandom_range(0, 3) == 0);
            rom[i] = w;
        end
        for (int c = 0; c < 800; c++) begin
            bus      = 16'($urandom);
            halt_req = ($urandom_range(0, 7) == 0);
            resume   = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (ir !== m_ir || tstate_reset_bar !== m_tsr || instr_done !== m_done ||
                halted !== (m_mode == M_HALT) || t_cnt !== m_t ||
                uaddr !== {m_ir[15:8], m_t} || ctrl !== exp_ctrl()) begin
                errors++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL rand_cycle%0d: ir=%h/%h tsr=%b/%b done=%b/%b halted=%b/%0d T=%0d/%0d ctrl=%h/%h (got/want)",
                             c, ir, m_ir, tstate_reset_bar, m_tsr, instr_done, m_done,
                             halted, (m_mode == M_HALT), t_cnt, m_t, ctrl, exp_ctrl());
                end
            end
        end
        halt_req = 1'b0;
        resume   = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
        rom[{8'h00, 3'd1}] = 16'h4000;          // II
        rom[{8'hA5, 3'd0}] = 16'h0123;
        rom[{8'hA5, 3'd1}] = 16'h4000;          // II
        rom[{8'hA5, 3'd3}] = 16'h8042;          // END
        rom[{8'h3C, 3'd1}] = 16'h4000;          // II, no END: wraps at T=7
        rom[{8'h3C, 3'd7}] = 16'h0777;
        rom[{8'h5A, 3'd1}] = 16'h0011;
        rom[{8'h5A, 3'd3}] = 16'h4000;          // II
        rom[{8'h5A, 3'd4}] = 16'h8000;          // END

        test_reset();
        test_ir_load();
        test_end_of_instr();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Consumes the 3-bit T-state produced by the T-state counter and drives that counter's reset2_bar input.
- Holds the instruction register and forms the microcode ROM address {opcode, T}.
- Gates the returned microword onto the control outputs.
- Detects instruction boundaries and implements a halt/resume state machine that freezes the CPU at T0 between instructions.

Parameters:
- OPC_BITS, 8, opcode width (IR[15:8]).
- T_BITS, 3, T-state width; T = 2^T_BITS-1 is the implicit last step.
- UW_BITS, 16, microword width.
- END_BIT, 15, microword bit: end of instruction, reset T-state.
- II_BIT, 14, microword bit: load IR from bus.

Ports:
- clk  in  1  system clock; this block acts on the rising edge (T changes on the falling edge).
- reset_bar  in  1  asynchronous, active-low reset.
- T  in  3  current T-state from the T-state counter.
- uword  in  16  microword from the microcode ROM for the current uaddr.
- bus  in  16  CPU data bus, source for IR loads.
- halt_req  in  1  level; request halt at the next instruction boundary.
- resume  in  1  single-cycle pulse; leave HALT.
- uaddr  out  11  microcode address = {ir[15:8], T}, combinational.
- ctrl  out  16  control word = uword in RUN; all zero in SYNC and HALT.
- ir  out  16  instruction register.
- tstate_reset_bar  out  1  registered; drives the T-state counter reset2_bar (low holds T=0).
- halted  out  1  high while in HALT.
- instr_done  out  1  registered one-cycle pulse after each instruction boundary.

Behaviour:
- Reset (reset_bar low, asynchronous, effective immediately, including mid-instruction):
  - ir=0, state=SYNC, tstate_reset_bar=0, halted=0, instr_done=0.
- States: SYNC, RUN, HALT.
  - SYNC: lasts exactly one clock after reset release; tstate_reset_bar stays 0, so T is guaranteed 0.
  - SYNC -> HALT if halt_req=1, else SYNC -> RUN (tstate_reset_bar goes 1 at that edge).
- RUN, each rising edge:
  - If uword[II_BIT]=1: ir <= bus.
  - Boundary = uword[END_BIT]=1 OR T=7.
  - On boundary: instr_done <= 1 for one cycle.
  - If halt_req=1 at the boundary: go to HALT, tstate_reset_bar <= 0.
  - Else if END_BIT=1: tstate_reset_bar <= 0 for exactly one cycle. The counter clears asynchronously, so the next rising edge samples T=0.
  - Else (T=7 without END_BIT): tstate_reset_bar stays 1; the counter wraps naturally.
  - Off boundary: tstate_reset_bar <= 1.
- HALT:
  - tstate_reset_bar=0, ctrl=0, halted=1, ir held.
  - resume=1 -> RUN at that edge: tstate_reset_bar <= 1, halted <= 0.
  - Next instruction starts at T0; the step at T=1 is sampled two edges after resume.
- Simultaneous events:
  - II_BIT and END_BIT in the same word: IR loads and the boundary applies.
  - resume and halt_req together in HALT: resume wins. The CPU re-halts at the next boundary if halt_req is still high.
  - resume outside HALT: ignored.
  - halt_req sampled only at boundaries; mid-instruction changes have no effect.
- uaddr always reflects the current ir and T, including in HALT, where uaddr = {opcode, 0}.
- Widths: uaddr = OPC_BITS+T_BITS; no arithmetic; T compared only against all-ones.

Decomposition:
- Shared package/header (ucode_defs):
  - END_BIT, II_BIT, opcode field position.
  - State encodings SYNC=2'b00, RUN=2'b01, HALT=2'b10.
- Sub-module seq_ctl: the 3-state FSM plus the registered tstate_reset_bar/instr_done/halted logic.
- Top level holds the IR and the address/ctrl gating.

Test Plan:
- Reset release, uword=0, T from a modelled 74161 (falling-edge count) -> first edge tstate_reset_bar=0, ctrl=0; second edge state RUN, tstate_reset_bar=1, T then counts 0,1,2.
- bus=16'hA53C, uword with II_BIT at T=1 -> ir=16'hA53C at that edge; uaddr=11'h528 at T=0, 11'h52B at T=3.
- END_BIT at T=3 -> instr_done pulses once, tstate_reset_bar low one cycle, next sampled T=0, then T=1.
- No END_BIT through T=7 -> instr_done pulses at T=7 edge, tstate_reset_bar never low, T wraps to 0.
- halt_req=1 raised at T=2, END_BIT at T=4:
  - Expected: halt taken at T=4 edge; halted=1, ctrl=0, T held 0 for 10 cycles.
  - Then resume pulse: RUN, T resumes 0,1.
- reset_bar pulsed low at T=5 mid-instruction -> ir=0, tstate_reset_bar=0 immediately (before next edge), SYNC sequence repeats.
